// File: rtl/muxn_scan_if.sv
// Bus bundle for the N-channel scanning mux: control, packed channel data and the
// registered selection result.
interface muxn_scan_if #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2
);
  logic                      en;
  logic                      mode;
  logic [SEL_W-1:0]          sel;
  logic [CHANNELS-1:0]       mask;
  logic [CHANNELS*WIDTH-1:0] data_in;
  logic [WIDTH-1:0]          y;
  logic                      y_valid;
  logic [SEL_W-1:0]          cur_ch;

  modport master (
    output en, mode, sel, mask, data_in,
    input  y, y_valid, cur_ch
  );

  modport slave (
    input  en, mode, sel, mask, data_in,
    output y, y_valid, cur_ch
  );
endinterface

// File: rtl/muxn_scan.sv
// N-channel W-bit mux with registered output: manual select or round-robin scan
// over the masked channels with a fixed dwell per channel.
//
// state  | meaning
// IDLE   | disabled, y_valid low, y/cur_ch hold
// MANUAL | channel picked by sel every edge
// SCAN   | round-robin over mask, DWELL edges per channel
module muxn_scan #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2,
  parameter int DWELL    = 4
) (
  input logic        clk,
  input logic        rst_n,
  muxn_scan_if.slave bus
);

  localparam int NCH_P = 2 ** SEL_W;
  localparam int CNT_W = $clog2(DWELL) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MANUAL = 2'd1,
    SCAN   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SEL_W-1:0] cur_ch_q, cur_ch_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             y_valid_q, y_valid_d;

  // Padded to the full select range so out-of-range indices read as empty channels.
  logic [WIDTH-1:0] ch_data [NCH_P];
  logic [NCH_P-1:0] mask_pad;

  assign mask_pad = NCH_P'(bus.mask);

  for (genvar i = 0; i < NCH_P; i++) begin : g_ch
    if (i < CHANNELS) begin : g_real
      assign ch_data[i] = bus.data_in[i*WIDTH +: WIDTH];
    end else begin : g_pad
      assign ch_data[i] = '0;
    end
  end

  // First enabled channel at or after start, wrapping modulo CHANNELS.
  function automatic logic [SEL_W-1:0] first_set(input int start,
                                                 input logic [NCH_P-1:0] m,
                                                 input logic [SEL_W-1:0] dflt);
    logic [SEL_W-1:0] res;
    logic             found;
    int               idx;
    res   = dflt;
    found = 1'b0;
    for (int k = 0; k < CHANNELS; k++) begin
      idx = (start + k) % CHANNELS;
      if (!found && m[idx]) begin
        res   = SEL_W'(idx);
        found = 1'b1;
      end
    end
    return res;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      cur_ch_q  <= '0;
      y_q       <= '0;
      y_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cur_ch_q  <= cur_ch_d;
      y_q       <= y_d;
      y_valid_q <= y_valid_d;
    end
  end

  always_comb begin
    state_d = IDLE;
    if (bus.en) begin
      state_d = bus.mode ? SCAN : MANUAL;
    end
  end

  always_comb begin
    logic [SEL_W-1:0] ch_new;
    cnt_d     = '0;
    cur_ch_d  = cur_ch_q;
    y_d       = y_q;
    y_valid_d = 1'b0;
    ch_new    = cur_ch_q;
    case (state_d)
      MANUAL: begin
        if (int'(bus.sel) < CHANNELS) begin
          cur_ch_d  = bus.sel;
          y_d       = ch_data[bus.sel];
          y_valid_d = 1'b1;
        end
      end
      SCAN: begin
        if (bus.mask != '0) begin
          if (state_q != SCAN) begin
            ch_new = first_set(int'(cur_ch_q), mask_pad, cur_ch_q);
          end else if (!mask_pad[cur_ch_q] || cnt_q == CNT_LAST) begin
            ch_new = first_set(int'(cur_ch_q) + 1, mask_pad, cur_ch_q);
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
          cur_ch_d  = ch_new;
          y_d       = ch_data[ch_new];
          y_valid_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign bus.y       = y_q;
  assign bus.y_valid = y_valid_q;
  assign bus.cur_ch  = cur_ch_q;

endmodule

// File: tb/tb_muxn_scan.sv
// Randomised and directed check of muxn_scan (4-channel and 3-channel instances)
// against a cycle-level behavioural model.
module tb_muxn_scan;

  logic clk;
  logic rst_n;

  muxn_scan_if #(.WIDTH(8), .CHANNELS(4), .SEL_W(2)) if_a ();
  muxn_scan_if #(.WIDTH(8), .CHANNELS(3), .SEL_W(2)) if_b ();

  muxn_scan #(.WIDTH(8), .CHANNELS(4), .SEL_W(2), .DWELL(4)) u_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_a.slave)
  );

  muxn_scan #(.WIDTH(8), .CHANNELS(3), .SEL_W(2), .DWELL(3)) u_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_b.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int ch;
    int y;
    bit v;
    int left;   // edges still to spend on ch after the current one
    int prev;   // 0 idle, 1 manual, 2 scan
  } model_t;

  model_t ma, mb;
  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic model_t model_reset(input int dwell);
    model_t s;
    s.ch = 0; s.y = 0; s.v = 1'b0; s.left = dwell - 1; s.prev = 0;
    return s;
  endfunction

  function automatic int search(input int start, input int mask, input int n);
    for (int k = 0; k < n; k++) begin
      if (((mask >> ((start + k) % n)) & 1) != 0) return (start + k) % n;
    end
    return start;
  endfunction

  function automatic model_t step(input model_t s, input int n, input int dwell,
                                  input bit en, input bit mode, input int sel,
                                  input int mask, input logic [31:0] data);
    model_t r;
    int     now;
    r   = s;
    now = !en ? 0 : (mode ? 2 : 1);
    r.left = dwell - 1;
    if (now == 0) begin
      r.v = 1'b0;
    end else if (now == 1) begin
      if (sel < n) begin
        r.ch = sel;
        r.y  = int'((data >> (8 * sel)) & 32'hFF);
        r.v  = 1'b1;
      end else begin
        r.v = 1'b0;
      end
    end else if (mask == 0) begin
      r.v = 1'b0;
    end else begin
      if (s.prev != 2) begin
        r.ch = search(s.ch, mask, n);
      end else if (((mask >> s.ch) & 1) == 0 || s.left == 0) begin
        r.ch = search(s.ch + 1, mask, n);
      end else begin
        r.left = s.left - 1;
      end
      r.y = int'((data >> (8 * r.ch)) & 32'hFF);
      r.v = 1'b1;
    end
    r.prev = now;
    return r;
  endfunction

  task automatic check_models();
    chk("a_y",      32'(if_a.y),       32'(ma.y));
    chk("a_valid",  32'(if_a.y_valid), 32'(ma.v));
    chk("a_cur_ch", 32'(if_a.cur_ch),  32'(ma.ch));
    chk("b_y",      32'(if_b.y),       32'(mb.y));
    chk("b_valid",  32'(if_b.y_valid), 32'(mb.v));
    chk("b_cur_ch", 32'(if_b.cur_ch),  32'(mb.ch));
  endtask

  task automatic drive(input bit en, input bit mode, input int sel, input int mask,
                       input logic [31:0] data);
    if_a.en = en;  if_a.mode = mode;  if_a.sel = 2'(sel);
    if_a.mask = 4'(mask);  if_a.data_in = data;
    if_b.en = en;  if_b.mode = mode;  if_b.sel = 2'(sel);
    if_b.mask = 3'(mask);  if_b.data_in = data[23:0];
  endtask

  task automatic cyc(input bit en, input bit mode, input int sel, input int mask,
                     input logic [31:0] data);
    @(negedge clk);
    drive(en, mode, sel, mask, data);
    ma = step(ma, 4, 4, en, mode, sel, mask & 15, data);
    mb = step(mb, 3, 3, en, mode, sel, mask & 7, data & 32'h00FF_FFFF);
    @(posedge clk);
    #1;
    check_models();
  endtask

  // Reset pulse placed between clock edges; outputs must clear without an edge.
  task automatic async_reset();
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_y",      32'(if_a.y),       32'h0);
    chk("rst_valid",  32'(if_a.y_valid), 32'h0);
    chk("rst_cur_ch", 32'(if_a.cur_ch),  32'h0);
    ma = model_reset(4);
    mb = model_reset(3);
    drive(1'b0, 1'b0, 0, 0, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  localparam logic [31:0] DATA0 = 32'h4433_2211;

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 0, 0, 32'h0);
    ma = model_reset(4);
    mb = model_reset(3);
    #12;
    check_models();
    @(negedge clk);
    rst_n = 1'b1;

    // manual select, live data tracking
    cyc(1'b1, 1'b0, 2, 0, DATA0);
    chk("man_y", 32'(if_a.y), 32'h33);
    chk("man_cur", 32'(if_a.cur_ch), 32'd2);
    cyc(1'b1, 1'b0, 2, 0, 32'h4450_2211 | 32'h000A_0000);
    chk("man_live", 32'(if_a.y), 32'h5A);
    cyc(1'b1, 1'b0, 2, 0, DATA0);
    async_reset();

    // full mask scan from channel 0, four edges per channel, wraps
    for (int i = 0; i < 17; i++) begin
      cyc(1'b1, 1'b1, 0, 4'b1111, DATA0);
      chk("full_y", 32'(if_a.y), 32'h11 * (((i / 4) % 4) + 1));
      chk("full_cur", 32'(if_a.cur_ch), 32'((i / 4) % 4));
    end

    // sparse mask, drop ch3 mid-dwell
    cyc(1'b0, 1'b0, 0, 0, DATA0);
    for (int i = 0; i < 6; i++) begin
      cyc(1'b1, 1'b1, 0, 4'b1010, DATA0);
      chk("sparse_cur", 32'(if_a.cur_ch), (i < 4) ? 32'd1 : 32'd3);
    end
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 1'b1, 0, 4'b0010, DATA0);
      chk("drop_y", 32'(if_a.y), 32'h22);
    end

    // empty mask, disable, back to manual, out-of-range select
    cyc(1'b1, 1'b1, 0, 0, DATA0);
    chk("empty_valid", 32'(if_a.y_valid), 32'h0);
    chk("empty_hold", 32'(if_a.y), 32'h22);
    cyc(1'b0, 1'b1, 0, 0, DATA0);
    chk("dis_valid", 32'(if_a.y_valid), 32'h0);
    cyc(1'b1, 1'b0, 1, 0, DATA0);
    chk("back_y", 32'(if_a.y), 32'h22);
    chk("back_valid", 32'(if_a.y_valid), 32'h1);
    cyc(1'b1, 1'b0, 3, 0, DATA0);
    chk("a_sel3_y", 32'(if_a.y), 32'h44);
    chk("b_sel3_valid", 32'(if_b.y_valid), 32'h0);
    chk("b_sel3_hold", 32'(if_b.y), 32'h22);

    // 3-channel scan wraps ch2 -> ch0
    for (int i = 0; i < 12; i++) begin
      cyc(1'b1, 1'b1, 0, 4'b0111, DATA0);
      chk("b_range", 32'(if_b.cur_ch < 2'd3), 32'h1);
    end

    for (int i = 0; i < 600; i++) begin
      automatic int r = int'($urandom_range(0, 99));
      automatic bit en = (r < 90);
      automatic bit mode = ($urandom_range(0, 3) != 0);
      automatic int sel = int'($urandom_range(0, 3));
      automatic int mask = int'(if_a.mask);
      if ($urandom_range(0, 7) == 0) mask = int'($urandom_range(0, 15));
      if (r == 99) async_reset();
      cyc(en, mode, sel, mask, $urandom);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
